// File: rtl/bit_deserializer_sync_rst.sv
// Serial-to-parallel front end: assembles framed serial bits into a DATA_W-bit word
// and presents it through a single-entry valid/ready holding buffer.
module bit_deserializer_sync_rst #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;

  logic [DATA_W-1:0]   shift_next;
  logic                last_data_bit;
  logic                parity_bit;
  logic                word_done;
  logic [DATA_W-1:0]   done_word;
  logic                done_err;
  logic                transfer;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                 input logic b);
    if (MSB_FIRST != 0)
      shift_in = {word[DATA_W-2:0], b};
    else
      shift_in = {b, word[DATA_W-1:1]};
  endfunction

  // Even parity: the parity bit must equal the XOR of all data bits.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] word,
                                           input logic pbit);
    parity_mismatch = (pbit != (^word));
  endfunction

  always_comb begin
    shift_next    = shift_in(shreg, bit_in);
    last_data_bit = (state == SHIFT) && bit_valid && !frame_start &&
                    (cnt == CNT_W'(DATA_W - 1));
    parity_bit    = (state == PARITY) && bit_valid && !frame_start;
    word_done     = 1'b0;
    done_word     = shift_next;
    done_err      = 1'b0;
    if (PARITY_EN != 0) begin
      word_done = parity_bit;
      done_word = shreg;
      done_err  = parity_mismatch(shreg, bit_in);
    end else begin
      word_done = last_data_bit;
    end
    transfer = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // frame_start always restarts collection and never carries a bit.
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= SHIFT;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            cnt   <= '0;
            shreg <= '0;
          end else if (bit_valid) begin
            shreg <= shift_next;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1))
              state <= (PARITY_EN != 0) ? PARITY : IDLE;
          end
        end
        PARITY: begin
          if (frame_start) begin
            state <= SHIFT;
            cnt   <= '0;
            shreg <= '0;
          end else if (bit_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          shreg <= '0;
        end
      endcase

      // Holding buffer: a completing word may replace one leaving in the same cycle.
      if (word_done) begin
        if (!out_valid || out_ready) begin
          data_out   <= done_word;
          parity_err <= done_err;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        out_valid  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_deserializer_sync_rst.sv
// Directed bench for bit_deserializer_sync_rst: default build (parity, MSB first)
// plus a no-parity LSB-first build sharing the same stimulus.
module tb_bit_deserializer_sync_rst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_in;
  logic       out_ready;

  logic       out_valid,  parity_err,  overrun;
  logic [7:0] data_out;
  logic       out_valid2, parity_err2, overrun2;
  logic [7:0] data_out2;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  bit_deserializer_sync_rst #(.DATA_W(8), .PARITY_EN(1), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .out_ready(out_ready), .out_valid(out_valid),
    .data_out(data_out), .parity_err(parity_err), .overrun(overrun)
  );

  bit_deserializer_sync_rst #(.DATA_W(8), .PARITY_EN(0), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .out_ready(out_ready), .out_valid(out_valid2),
    .data_out(data_out2), .parity_err(parity_err2), .overrun(overrun2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, take the edge, then sample 1 time unit later.
  task automatic cyc(input logic fs, input logic bv, input logic b, input logic rdy);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = b;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // frame_start cycle also raises bit_valid to show it carries no bit.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic rdy_body, input logic rdy_last);
    cyc(1'b1, 1'b1, 1'b1, rdy_body);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, d[i], rdy_body);
    cyc(1'b0, 1'b1, p, rdy_last);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_valid",  {15'd0, out_valid},  16'd0);
    chk("rst_data",   {8'd0, data_out},    16'd0);
    chk("rst_perr",   {15'd0, parity_err}, 16'd0);
    chk("rst_ovr",    {15'd0, overrun},    16'd0);
    rst_n = 1'b1;

    // 1: 0xA5 with correct parity
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("t1_valid", {15'd0, out_valid},  16'd1);
    chk("t1_data",  {8'd0, data_out},    16'h00A5);
    chk("t1_perr",  {15'd0, parity_err}, 16'd0);
    chk("t1_ovr",   {15'd0, overrun},    16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid_drop", {15'd0, out_valid}, 16'd0);
    chk("t1_data_hold",  {8'd0, data_out},   16'h00A5);

    // 2: wrong parity, then 0x3C with correct parity
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("t2_data", {8'd0, data_out},    16'h00A5);
    chk("t2_perr", {15'd0, parity_err}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_perr_clr", {15'd0, parity_err}, 16'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    chk("t2b_data",  {8'd0, data_out},    16'h003C);
    chk("t2b_perr",  {15'd0, parity_err}, 16'd0);
    chk("t2b_valid", {15'd0, out_valid},  16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: overrun while the buffer is held
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    chk("t3_data1", {8'd0, data_out},   16'h0011);
    chk("t3_ovr0",  {15'd0, overrun},   16'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr",       {15'd0, overrun},   16'd1);
    chk("t3_data_keep", {8'd0, data_out},   16'h0011);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr_pulse", {15'd0, overrun},   16'd0);
    chk("t3_valid",     {15'd0, out_valid}, 16'd1);
    chk("t3_data_stab", {8'd0, data_out},   16'h0011);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_xfer", {15'd0, out_valid}, 16'd0);

    // 4: transfer and completion on the same edge
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    chk("t4_data",  {8'd0, data_out},   16'h0022);
    chk("t4_valid", {15'd0, out_valid}, 16'd1);
    chk("t4_ovr",   {15'd0, overrun},   16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // 5: abort after 4 bits, gap, restart (with a simultaneous bit_valid)
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("t5_data",  {8'd0, data_out},    16'h005A);
    chk("t5_perr",  {15'd0, parity_err}, 16'd0);
    chk("t5_valid", {15'd0, out_valid},  16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // 6: reset mid-frame while a word is held
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("t6_rst_valid", {15'd0, out_valid},  16'd0);
    chk("t6_rst_data",  {8'd0, data_out},    16'd0);
    chk("t6_rst_perr",  {15'd0, parity_err}, 16'd0);
    chk("t6_rst_ovr",   {15'd0, overrun},    16'd0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
    chk("t6_data",  {8'd0, data_out},    16'h000F);
    chk("t6_perr",  {15'd0, parity_err}, 16'd0);

    // 6b: no-parity, LSB-first build
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk("t6b_rst_valid", {15'd0, out_valid2}, 16'd0);
    chk("t6b_rst_data",  {8'd0, data_out2},   16'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i < 4), 1'b1);
    chk("t6b_valid", {15'd0, out_valid2},  16'd1);
    chk("t6b_data",  {8'd0, data_out2},    16'h000F);
    chk("t6b_perr",  {15'd0, parity_err2}, 16'd0);
    chk("t6b_ovr",   {15'd0, overrun2},    16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6b_xfer",  {15'd0, out_valid2},  16'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bit_deserializer_sync_rst.md
Name: bit_deserializer_sync_rst

Overview:
- Serial-to-parallel front end. Collects framed serial bits into a DATA_W-bit word.
- Feeds the word into the downstream byte register through a single-entry valid/ready holding buffer.
- Optionally checks even parity per frame and flags overrun when a word completes while the buffer is still occupied.
- Sits directly upstream of the byte capture stage; its data_out drives that stage's data input.

Parameters:
DATA_W, 8, data bits per frame (legal range 2..16).
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.
MSB_FIRST, 1, 1 = first data bit received lands in data_out[DATA_W-1]; 0 = lands in data_out[0].

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk only.
frame_start  input  1  one-cycle pulse that opens a new frame; carries no data bit.
bit_valid  input  1  bit_in is valid this cycle.
bit_in  input  1  serial data or parity bit.
out_ready  input  1  downstream accepts data_out this cycle.
out_valid  output  1  data_out holds an unconsumed word.
data_out  output  DATA_W  assembled word.
parity_err  output  1  parity mismatch on the word currently in data_out; always 0 when PARITY_EN=0.
overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a posedge):
  - FSM goes to IDLE; bit counter and shift register clear.
  - out_valid=0, data_out=0, parity_err=0, overrun=0.
  - Reset wins over every other input that cycle. Reset mid-frame discards the partial word; reset while out_valid=1 discards the held word.
- FSM states: IDLE, SHIFT, PARITY.
  - IDLE: bit_valid ignored. frame_start -> SHIFT, counter=0.
  - SHIFT: each bit_valid shifts bit_in in per MSB_FIRST and increments the counter. On the DATA_W-th bit: if PARITY_EN -> PARITY, else complete the word and go to IDLE.
  - PARITY: the next bit_valid is the parity bit. Mismatch = bit_in != XOR of the data bits. Complete the word and go to IDLE.
  - frame_start in SHIFT or PARITY: abort. Partial word discarded, counter=0, stay in or enter SHIFT, no flags. If bit_valid is high in the same cycle, it is ignored (frame_start carries no bit).
  - Gaps (bit_valid=0) are allowed anywhere in a frame; no timeout.
- Completion happens on the edge that samples the final bit (latency 0 edges: out_valid visible in the following cycle).
  - Buffer free, or out_valid & out_ready that same cycle: load data_out, load parity_err with the mismatch result, out_valid=1.
  - Buffer occupied and out_ready=0: keep the old data_out and parity_err, drop the new word, pulse overrun for exactly one cycle.
- Handshake:
  - A transfer occurs when out_valid & out_ready.
  - After a transfer with no simultaneous completion: out_valid=0. data_out holds its last value; parity_err clears.
  - data_out is stable while out_valid=1 and out_ready=0.
- Back-to-back frames: frame_start may arrive in the cycle right after completion; no dead cycle required.
- Counter is wide enough for DATA_W; it never wraps inside a frame.

Test Plan:
1. Reset, frame_start, bits 1,0,1,0,0,1,0,1, parity 0, out_ready=1 -> data_out=0xA5, out_valid high one cycle, parity_err=0, overrun=0.
2. Same frame with parity bit 1 -> data_out=0xA5, parity_err=1. Next frame 0x3C (MSB-first 0,0,1,1,1,1,0,0), parity 0 -> parity_err=0.
3. out_ready=0. Frame 0x11 then frame 0x22 -> data_out stays 0x11, overrun pulses exactly one cycle on the edge of 0x22's parity bit. Raise out_ready -> 0x11 transfers, out_valid=0.
4. out_valid=1 (0x11), out_ready=1 on the same edge 0x22 completes -> 0x11 transfers, data_out=0x22, out_valid stays 1, no overrun.
5. frame_start, 4 bits, frame_start again, then full frame 0x5A with parity 0 -> data_out=0x5A; the partial bits do not leak.
6. rst_n low for one cycle after 5 bits of a frame while out_valid=1 -> all outputs 0. Next complete frame 0x0F (parity 0) -> data_out=0x0F. Repeat with PARITY_EN=0, MSB_FIRST=0: bits 1,1,1,1,0,0,0,0 -> data_out=0x0F.
